// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: the left word then the right word, each MSB first.
// WS leads the data by one slot. A frame is loaded every 2*WIDTH bit clocks with no idle slot.
module i2s_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic               SCK,
    input  logic               nreset,
    input  logic [2*WIDTH-1:0] LoadData,
    output logic               SerialData,
    output logic               WS,
    output logic               Ready
);

    localparam int FRAME = 2 * WIDTH;
    localparam int CW    = $clog2(FRAME);

    localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME - 1);
    localparam logic [CW-1:0] WS_FIRST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] WS_LAST   = CW'(FRAME - 2);

    logic [CW-1:0]    word_counter;
    logic [CW-1:0]    counter_nxt;
    logic [FRAME-1:0] shift_reg;
    logic [FRAME-1:0] shift_nxt;
    logic             sd_nxt;
    logic             ws_nxt;
    logic             ready_nxt;

    // WS and Ready are decoded from the slot being entered so that both stay registered.
    always_comb begin
        counter_nxt = word_counter + CW'(1);
        shift_nxt   = {shift_reg[FRAME-2:0], 1'b0};
        sd_nxt      = shift_reg[FRAME-1];
        if (word_counter == LAST_SLOT) begin
            counter_nxt = '0;
            shift_nxt   = {LoadData[FRAME-2:0], 1'b0};
            sd_nxt      = LoadData[FRAME-1];
        end
        ws_nxt    = (counter_nxt >= WS_FIRST) && (counter_nxt <= WS_LAST);
        ready_nxt = (counter_nxt == LAST_SLOT);
    end

    always_ff @(posedge SCK) begin
        if (nreset) begin
            word_counter <= LAST_SLOT;
            shift_reg    <= '0;
            SerialData   <= 1'b0;
            WS           <= 1'b0;
            Ready        <= 1'b1;
        end else begin
            word_counter <= counter_nxt;
            shift_reg    <= shift_nxt;
            SerialData   <= sd_nxt;
            WS           <= ws_nxt;
            Ready        <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter at WIDTH=8 and WIDTH=4.
// Frame bits are queued at each modelled load edge and then popped one per slot.
module tb_i2s_transmitter;

    logic        sck = 1'b0;
    logic        rst;
    logic [15:0] ld8;
    logic [7:0]  ld4;
    logic        sd8, ws8, rdy8;
    logic        sd4, ws4, rdy4;

    always #5 sck = ~sck;

    i2s_transmitter #(.WIDTH(8)) dut8 (
        .SCK(sck), .nreset(rst), .LoadData(ld8),
        .SerialData(sd8), .WS(ws8), .Ready(rdy8)
    );

    i2s_transmitter #(.WIDTH(4)) dut4 (
        .SCK(sck), .nreset(rst), .LoadData(ld4),
        .SerialData(sd4), .WS(ws4), .Ready(rdy4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int slot8   = 15;
    int slot4   = 7;
    bit e_sd8   = 1'b0;
    bit e_sd4   = 1'b0;
    bit q8[$];
    bit q4[$];
    int rdy_cnt8;
    int rdy_cnt4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one bit clock, update the reference model, then check on the falling edge.
    task automatic tick();
        @(posedge sck);
        if (rst) begin
            slot8 = 15; q8.delete(); e_sd8 = 1'b0;
            slot4 = 7;  q4.delete(); e_sd4 = 1'b0;
        end else begin
            if (slot8 == 15) begin
                slot8 = 0;
                for (int i = 15; i >= 0; i--) q8.push_back(ld8[i]);
            end else begin
                slot8++;
            end
            e_sd8 = q8.pop_front();
            if (slot4 == 7) begin
                slot4 = 0;
                for (int i = 7; i >= 0; i--) q4.push_back(ld4[i]);
            end else begin
                slot4++;
            end
            e_sd4 = q4.pop_front();
        end
        @(negedge sck);
        chk("sd8",  32'(sd8),  32'(e_sd8));
        chk("ws8",  32'(ws8),  32'(slot8 >= 7 && slot8 <= 14));
        chk("rdy8", 32'(rdy8), 32'(slot8 == 15));
        chk("cnt8", 32'(dut8.word_counter), 32'(slot8));
        chk("sd4",  32'(sd4),  32'(e_sd4));
        chk("ws4",  32'(ws4),  32'(slot4 >= 3 && slot4 <= 6));
        chk("rdy4", 32'(rdy4), 32'(slot4 == 7));
        chk("cnt4", 32'(dut4.word_counter), 32'(slot4));
    endtask

    initial begin
        rst = 1'b1;
        ld8 = 16'h8988;
        ld4 = 8'hB4;
        @(negedge sck);
        tick();
        tick();
        rst = 1'b0;

        // Two frames with 8988 and B4 held: data, WS lead and counter sequence.
        for (int i = 0; i < 32; i++) tick();

        // A change at slot 5 must not disturb the frame in flight; FFFF loaded at slot 15.
        while (slot8 != 5) tick();
        ld8 = 16'h0000;
        while (slot8 != 15) tick();
        ld8 = 16'hFFFF;
        for (int i = 0; i < 16; i++) tick();

        // Ready cadence over 64 cycles.
        rdy_cnt8 = 0;
        rdy_cnt4 = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (rdy8) rdy_cnt8++;
            if (rdy4) rdy_cnt4++;
        end
        chk("rdy8_count", 32'(rdy_cnt8), 32'd4);
        chk("rdy4_count", 32'(rdy_cnt4), 32'd8);

        // Reset during slot 9 of an A5C3 frame, then restart.
        while (slot8 != 15) tick();
        ld8 = 16'hA5C3;
        while (slot8 != 9) tick();
        rst = 1'b1;
        tick();
        chk("rst_sd8",  32'(sd8),  32'd0);
        chk("rst_ws8",  32'(ws8),  32'd0);
        chk("rst_rdy8", 32'(rdy8), 32'd1);
        chk("rst_cnt8", 32'(dut8.word_counter), 32'd15);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises stereo PCM frames onto a Philips I2S bus: WIDTH-bit left word, then WIDTH-bit right word, MSB first.
- Drives word-select (WS) with the standard one-bit lead over the data.
- Sits between an audio sample source (parallel LoadData with a Ready strobe) and an external DAC/codec clocked by the same bit clock SCK.

Parameters:
- WIDTH, 8, bits per channel word. Frame length is 2*WIDTH bit slots. Legal range is WIDTH >= 2.

Ports:
- SCK  input  1  bit clock; every register updates on the rising edge.
- nreset  input  1  synchronous, active-high reset (asserted = 1, despite the name).
- LoadData  input  2*WIDTH  frame to transmit. [2*WIDTH-1:WIDTH] is the left word; [WIDTH-1:0] is the right word.
- SerialData  output  1  I2S serial data (SD), registered.
- WS  output  1  word select: 0 = left, 1 = right; registered.
- Ready  output  1  high during the slot in which LoadData is sampled at the closing rising edge.

Behaviour:
- Internal slot counter WordCounter, range 0..2*WIDTH-1; wraps 2*WIDTH-1 -> 0 with no idle slot. Frames are continuous back-to-back.
- Internal shift register, 2*WIDTH bits.
- Reset (nreset=1 at a rising edge):
  - WordCounter = 2*WIDTH-1, shift register = 0, SerialData = 0, WS = 0, Ready = 1.
  - Reset overrides everything. Reset mid-frame aborts the frame immediately; no partial bits resume.
- Load: at any rising edge where WordCounter == 2*WIDTH-1 and reset is not asserted:
  - LoadData is captured.
  - SerialData <= LoadData[2*WIDTH-1].
  - Shift register <= LoadData shifted left by 1.
  - WordCounter <= 0.
- Shift: at other edges, WordCounter increments, SerialData <= shift register MSB, and the shift register shifts left by one, filling with 0.
- Data mapping: during slot k (WordCounter == k), SerialData = frame bit (2*WIDTH-1-k).
  - Slots 0..WIDTH-1 carry the left word, MSB first.
  - Slots WIDTH..2*WIDTH-1 carry the right word, MSB first.
- WS, one-bit I2S lead:
  - WS = 1 in slots WIDTH-1 .. 2*WIDTH-2.
  - WS = 0 in slot 2*WIDTH-1 and slots 0 .. WIDTH-2.
  - So WS changes one slot before the first bit of each word.
- Ready:
  - Ready = 1 exactly in slot 2*WIDTH-1; 0 otherwise.
  - Registered, i.e. asserted by the edge that enters slot 2*WIDTH-1.
  - Period 2*WIDTH cycles, one cycle wide.
  - Ready is also 1 during reset and in the first cycle after reset release, so the first frame is loaded at the first rising edge after nreset deasserts.
- LoadData timing:
  - LoadData is only sampled at load edges. Changes at any other time have no effect on the frame in flight.
  - Source contract: LoadData stable around the rising edge that ends a Ready=1 cycle.
- Latency: LoadData MSB appears on SerialData in the cycle immediately following the load edge, i.e. slot 0.
- Timing for consumers: outputs change only just after rising edges. Consumers sample on the falling edge.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then single frame, WIDTH=8, LoadData=16'h8988 held:
  - Ready=1 until the first edge after release.
  - SerialData over slots 0..15 = 1,0,0,0,1,0,0,1, 1,0,0,0,1,0,0,0.
  - WordCounter 0..15.
- WS pattern over two consecutive frames:
  - WS=0 in slots 15, 0..6; WS=1 in slots 7..14.
  - Transitions occur exactly one slot before slots 0 and 8.
- Reload, LoadData changed to 16'hFFFF during slot 15 (Ready=1):
  - Next frame SerialData is all 1s.
  - Changing LoadData in mid-frame slot 5 instead leaves the current frame bits unchanged.
- Ready cadence:
  - Over 64 cycles, Ready is high exactly 4 times, each for one cycle, always coinciding with WordCounter==15.
- Reset mid-frame:
  - Assert nreset during slot 9 of a frame with data 16'hA5C3.
  - SerialData=0, WS=0, Ready=1, WordCounter=15 after the reset edge.
  - After release, the next frame restarts with the LoadData MSB in slot 0.
- Parameter variation, WIDTH=4, LoadData=8'hB4:
  - SerialData slots 0..7 = 1,0,1,1,0,1,0,0.
  - WS=1 in slots 3..6; Ready period 8.
